muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the execute stage, beside the ALU.
//  Takes forwarded execute-stage operands and runs MULT/MULTU/DIV/DIVU over several cycles.
//  Writes the 2*WIDTH result into its own HI/LO registers.
//  Signals busy so the hazard unit stalls later mfhi/mflo/mult/div until done.
// PARAMETERS
//  WIDTH  32  operand width; also the iteration count (1 bit per cycle)
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-low reset (0 = reset)
//  start    in   1      launch op; sampled only in IDLE or DONE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  srca     in   WIDTH  multiplicand / dividend (rs, post-forwarding)
//  srcb     in   WIDTH  multiplier / divisor (rt, post-forwarding)
//  flush    in   1      abort the op in flight (execute flush)
//  busy     out  1      op in progress (RUN or FIX)
//  done     out  1      one-cycle pulse: hi/lo hold the new result
//  divzero  out  1      pulses with done when a DIV/DIVU had srcb==0
//  hi       out  WIDTH  MULT: upper product; DIV: remainder
//  lo       out  WIDTH  MULT: lower product; DIV: quotient
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE
//   - busy=done=divzero=0, hi=lo=0
//   - all internal operands and counter cleared
//  States IDLE -> RUN -> FIX -> DONE -> IDLE (or DONE -> RUN on start).
//  IDLE/DONE, on start & ~flush:
//   - latch op and the operand magnitudes; signed ops take |x| and record the result signs
//   - counter=0; go to RUN
//  RUN, one bit per cycle for WIDTH cycles:
//   - MUL: shift-add
//   - DIV: restoring shift-subtract
//   - leaves RUN after counter==WIDTH-1
//  FIX, one cycle:
//   - apply signs: product negated if signs differ; quotient negated if signs differ;
//     remainder takes the dividend's sign
//   - register the result into hi/lo on the edge leaving FIX
//  DONE, one cycle:
//   - done=1, busy=0
//   - then IDLE, unless start is taken (back-to-back ops allowed)
//  Latency: start sampled at edge E0; hi/lo update at edge E0+WIDTH+1;
//   done is high in the cycle after that edge; busy is high for exactly WIDTH+1 cycles.
//  start while busy is ignored (the hazard unit must not issue it).
//  flush:
//   - in RUN/FIX: go to IDLE next edge; hi/lo unchanged; no done
//   - in the same cycle as start: flush wins and start is dropped
//  Divide by zero (srcb==0, DIV or DIVU):
//   - lo={WIDTH{1}}, hi=srca (unmodified)
//   - divzero=1 with done
//   - full latency kept (no early exit)
//  Overflow: DIV -2^(WIDTH-1) / -1 gives lo=0x80000000, hi=0 (wraps, no trap).
//  hi/lo change only on the edge leaving FIX, or on reset.
//  Reset mid-op: immediate abort; all outputs cleared.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done at cycle WIDTH+2 after start
//  MULT -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 33 cycles
//  DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
//  DIVU 100/7 -> lo=14, hi=2; then DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, divzero=1
//  MULT started, flush at RUN cycle 10 -> no done, hi/lo keep old values, busy=0 next cycle
//  reset=0 at RUN cycle 20 -> all outputs 0 at once; new MULTU 2*3 afterwards -> lo=6, hi=0

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the execute-stage ALU.
// One result bit per cycle; the signed result is written to its own hi/lo.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_w, rem_w, sub_w;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   quo_n, rem_n;

    // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sgn    = ~op[0];
        mag_a  = (sgn && srca[WIDTH-1]) ? (~srca + ONE_W) : srca;
        mag_b  = (sgn && srcb[WIDTH-1]) ? (~srcb + ONE_W) : srcb;
        add_w  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        rem_w  = p_q[2*WIDTH-1:WIDTH-1];
        sub_w  = rem_w - {1'b0, m_q};
        prod_n = ~p_q + ONE_P;
        quo_n  = ~p_q[WIDTH-1:0] + ONE_W;
        rem_n  = ~p_q[2*WIDTH-1:WIDTH] + ONE_W;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        m_d      = m_q;
        p_d      = p_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !flush) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    rneg_d   = sgn & srca[WIDTH-1];
                    dz_d     = op[1] & (srcb == '0);
                    m_d      = op[1] ? mag_b : mag_a;
                    p_d      = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        p_d = sub_w[WIDTH]
                            ? {rem_w[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                            : {sub_w[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = p_q[0]
                            ? {add_w, p_q[WIDTH-1:1]}
                            : {1'b0, p_q[2*WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = neg_q ? prod_n : p_q;
                    end else begin
                        // divide by zero leaves the dividend, re-signed, in hi
                        hi_d = rneg_q ? rem_n : p_q[2*WIDTH-1:WIDTH];
                        if (dz_q) begin
                            lo_d = '1;
                        end else begin
                            lo_d = neg_q ? quo_n : p_q[WIDTH-1:0];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            m_q      <= '0;
            p_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            m_q      <= m_d;
            p_q      <= p_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_FIX);
    assign done    = (state_q == S_DONE);
    assign divzero = done & dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
